// File: rtl/sram_rd_arbiter_if.sv
// Bus bundle between two SRAM read requesters (query/target parsers) and the
// shared read port arbiter. The arbiter takes the slave view; whatever drives
// requests and the SRAM read data takes the master view.
`ifndef SRAM_WORD_WIDTH
`define SRAM_WORD_WIDTH 12
`endif
`ifndef SRAM_ADDR_BIT
`define SRAM_ADDR_BIT 8
`endif

interface sram_rd_arbiter_if #(
    parameter int SRAM_WORD_WIDTH = `SRAM_WORD_WIDTH,
    parameter int SRAM_ADDR_BIT   = `SRAM_ADDR_BIT
);
    logic                       q_request_i;
    logic [SRAM_ADDR_BIT-1:0]   q_addr_i;
    logic                       t_request_i;
    logic [SRAM_ADDR_BIT-1:0]   t_addr_i;
    logic [SRAM_WORD_WIDTH-1:0] sram_data_i;
    logic                       sram_rd_o;
    logic [SRAM_ADDR_BIT-1:0]   sram_addr_o;
    logic [SRAM_WORD_WIDTH-1:0] data_o;
    logic                       q_valid_o;
    logic                       t_valid_o;
    logic [1:0]                 grant_o;
    logic                       busy_o;

    modport slave (
        input  q_request_i, q_addr_i, t_request_i, t_addr_i, sram_data_i,
        output sram_rd_o, sram_addr_o, data_o, q_valid_o, t_valid_o,
               grant_o, busy_o
    );

    modport master (
        output q_request_i, q_addr_i, t_request_i, t_addr_i, sram_data_i,
        input  sram_rd_o, sram_addr_o, data_o, q_valid_o, t_valid_o,
               grant_o, busy_o
    );
endinterface

// File: rtl/sram_rd_arbiter.sv
// Round-robin arbiter sharing one SRAM read port between the query and target
// parsers. One read in flight at a time: IDLE -> ISSUE -> WAIT -> RESP -> HOLD.
// The owner and absolute address are frozen for the whole transaction.
`ifndef SRAM_WORD_WIDTH
`define SRAM_WORD_WIDTH 12
`endif
`ifndef SRAM_ADDR_BIT
`define SRAM_ADDR_BIT 8
`endif

module sram_rd_arbiter #(
    parameter int SRAM_WORD_WIDTH = `SRAM_WORD_WIDTH,
    parameter int SRAM_ADDR_BIT   = `SRAM_ADDR_BIT,
    parameter int RD_LAT          = 1,
    parameter int Q_BASE          = 0,
    parameter int T_BASE          = 2**(SRAM_ADDR_BIT-1)
) (
    input logic              clk,
    input logic              rst,
    sram_rd_arbiter_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_RESP  = 3'd3,
        S_HOLD  = 3'd4
    } state_t;

    // Bases truncated to the address width so the sums wrap naturally.
    localparam logic [SRAM_ADDR_BIT-1:0] Q_BASE_W = SRAM_ADDR_BIT'(Q_BASE);
    localparam logic [SRAM_ADDR_BIT-1:0] T_BASE_W = SRAM_ADDR_BIT'(T_BASE);
    localparam logic [2:0]               LAT_W    = 3'(RD_LAT);

    state_t                     r_state, r_state_next;
    logic [1:0]                 r_grant, r_grant_next;     // {t,q} one-hot owner
    logic [SRAM_ADDR_BIT-1:0]   r_addr,  r_addr_next;      // absolute SRAM address
    logic [2:0]                 r_cnt,   r_cnt_next;       // read latency countdown
    logic [SRAM_WORD_WIDTH-1:0] r_data,  r_data_next;      // last returned word
    logic                       r_last_t, r_last_t_next;   // 1: target served last

    logic                       w_any_req;
    logic                       w_pick_t;
    logic [SRAM_ADDR_BIT-1:0]   w_q_abs;
    logic [SRAM_ADDR_BIT-1:0]   w_t_abs;

    assign w_any_req = bus.q_request_i | bus.t_request_i;
    // Target wins when it is alone, or on a tie when query was served last.
    assign w_pick_t  = bus.t_request_i & (~bus.q_request_i | ~r_last_t);
    assign w_q_abs   = bus.q_addr_i + Q_BASE_W;
    assign w_t_abs   = bus.t_addr_i + T_BASE_W;

    // Next-state and next-register values; everything defaults to holding.
    always_comb begin
        r_state_next  = r_state;
        r_grant_next  = r_grant;
        r_addr_next   = r_addr;
        r_cnt_next    = r_cnt;
        r_data_next   = r_data;
        r_last_t_next = r_last_t;
        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    r_grant_next = w_pick_t ? 2'b10 : 2'b01;
                    r_addr_next  = w_pick_t ? w_t_abs : w_q_abs;
                    r_state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                r_cnt_next   = LAT_W;
                r_state_next = S_WAIT;
            end
            S_WAIT: begin
                r_cnt_next = r_cnt - 3'd1;
                if (r_cnt == 3'd1) begin
                    r_data_next  = bus.sram_data_i;
                    r_state_next = S_RESP;
                end
            end
            S_RESP: begin
                r_last_t_next = r_grant[1];
                r_state_next  = S_HOLD;
            end
            S_HOLD: begin
                // Requesters release one cycle after valid; skip that cycle.
                r_grant_next = 2'b00;
                r_state_next = S_IDLE;
            end
            default: begin
                r_state_next = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_grant  <= 2'b00;
            r_addr   <= '0;
            r_cnt    <= 3'd0;
            r_data   <= '0;
            r_last_t <= 1'b0;
        end else begin
            r_state  <= r_state_next;
            r_grant  <= r_grant_next;
            r_addr   <= r_addr_next;
            r_cnt    <= r_cnt_next;
            r_data   <= r_data_next;
            r_last_t <= r_last_t_next;
        end
    end

    // All outputs decode registered state only, so they are glitch-free.
    assign bus.sram_rd_o   = (r_state == S_ISSUE);
    assign bus.sram_addr_o = r_addr;
    assign bus.data_o      = r_data;
    assign bus.q_valid_o   = (r_state == S_RESP) & r_grant[0];
    assign bus.t_valid_o   = (r_state == S_RESP) & r_grant[1];
    assign bus.grant_o     = r_grant;
    assign bus.busy_o      = (r_state != S_IDLE);

endmodule
